uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- 8N1 UART transmitter that sits directly downstream of the baud clock divider.
- Consumes the divider's square-wave baud clock, which is generated in the i_clock domain.
- Detects the rising edge of that clock in the i_clock domain and advances one bit per baud period.
- Bytes written by the CPU-side peripheral bus are buffered in an internal FIFO and transmitted back-to-back on o_tx.

Parameters:
- FIFO_DEPTH, 16, number of buffered bytes; must be a power of two, at least 2.
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of the occupancy counter; derived, do not override.

Ports:
- i_reset  input  1  synchronous, active-high reset.
- i_clock  input  1  system clock; all state changes on its rising edge.
- i_baud_clock  input  1  baud square wave from the clock divider, same clock domain, registered at the source.
- i_wr  input  1  write strobe; one byte is pushed per cycle in which it is high.
- i_wdata  input  8  byte to push; sampled when i_wr=1.
- o_full  output  1  FIFO full (count == FIFO_DEPTH).
- o_empty  output  1  FIFO empty (count == 0).
- o_overflow  output  1  one-cycle pulse when a write is dropped.
- o_busy  output  1  high when the state is not IDLE or the FIFO is not empty.
- o_tx  output  1  serial line; idles high.

Behaviour:
- Reset is synchronous, active-high (i_reset), on clock i_clock.
- Reset values:
  - o_tx=1, o_full=0, o_empty=1, o_overflow=0, o_busy=0.
  - state=IDLE, FIFO pointers and count=0, baud_q=0.
- Tick generation:
  - baud_q registers i_baud_clock every cycle.
  - tick = i_baud_clock & ~baud_q, i.e. one i_clock-wide pulse per baud period.
  - All serializer state transitions happen only on cycles where tick=1.
- FIFO behaviour:
  - A write is accepted iff i_wr=1 and o_full=0, judged on the registered flag.
  - A write while full is dropped, even with a simultaneous pop: o_overflow=1 for that cycle and the FIFO is unchanged.
  - A simultaneous accepted push and pop leaves count unchanged; both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_full and o_empty are registered and reflect count after the edge.
- State machine (each transition taken only on tick):
  - IDLE, o_tx=1: if o_empty=0, pop the head into shift[7:0], set o_tx<=0, go to START. Otherwise stay.
  - START: o_tx<=shift[0], shift>>=1, bitcnt<=0, go to DATA.
  - DATA:
    - if bitcnt==7: o_tx<=1, go to STOP.
    - else: o_tx<=shift[0], shift>>=1, bitcnt<=bitcnt+1.
  - STOP: if o_empty=0, pop the next byte, o_tx<=0, go to START (back-to-back, no idle gap). Otherwise go to IDLE with o_tx staying 1.
- Framing:
  - Each bit is held for exactly one tick interval; the line is LSB first.
  - One frame is 10 tick intervals: start, d0..d7, stop.
  - Back-to-back frames contain no extra idle bit.
- Latency:
  - A byte written at cycle N is visible (o_empty=0) at N+1.
  - Its start bit begins at the first tick at or after N+1 while the state is IDLE or STOP.
- o_busy is registered or combinational from state/count; it must be 0 only when state=IDLE and count=0.
- Reset mid-frame: the next edge forces o_tx=1 and IDLE, and discards the FIFO contents. A partial frame is never resumed.
- A static i_baud_clock (no edges) freezes the serializer; FIFO writes still work.
- A write on the same cycle as a tick in IDLE with an empty FIFO is not transmitted at that tick; it waits for the next tick.

Test Plan:
- Single byte:
  - Stimulus: bench toggles i_baud_clock every 4 cycles (tick every 8); write 0xA5.
  - Response: o_tx = 0, then 1,0,1,0,0,1,0,1, then 1.
  - Each bit lasts 8 cycles; o_busy falls after the stop bit; o_empty=1.
- Back-to-back:
  - Stimulus: write 0x00 then 0xFF on consecutive cycles.
  - Response: the stop bit of frame 1 is followed immediately by the start bit of frame 2; 20 bit periods total (160 cycles).
- Fill/overflow:
  - Stimulus: freeze i_baud_clock and write 17 bytes.
  - Response: o_full=1 after the 16th write; o_overflow pulses once on the 17th; after unfreezing, exactly 16 frames go out in write order.
- Simultaneous push/pop:
  - Stimulus: with count=1, write a byte on the same cycle a tick pops in IDLE.
  - Response: count stays 1 and both bytes are transmitted in order.
- Reset mid-frame:
  - Stimulus: assert i_reset during bit d3 of 0x3C with 2 bytes queued.
  - Response: o_tx=1 on the next cycle, o_empty=1, o_busy=0; no further frames are sent.
- Tick edge detection:
  - Stimulus: hold i_baud_clock high for 50 cycles, then drop it and raise it again.
  - Response: exactly one tick per rising edge; the held-high level never produces repeated advances.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a byte FIFO.
// Advances one bit per rising edge of the divider's baud clock.
module uart_tx_serializer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic       i_reset,
  input  logic       i_clock,
  input  logic       i_baud_clock,
  input  logic       i_wr,
  input  logic [7:0] i_wdata,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_overflow,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 baud_q;
  logic                 tick;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic                 tx_q, tx_d;
  logic                 push;
  logic                 pop;

  assign tick = i_baud_clock & ~baud_q;
  assign push = i_wr & ~full_q;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end
        end
        START: begin
          tx_d     = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = 3'd0;
          state_d  = DATA;
        end
        DATA: begin
          if (bitcnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d     = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        STOP: begin
          // Chain straight into the next start bit when data is waiting.
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    full_d  = (count_d == CNT_WIDTH'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      baud_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      shift_q  <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= i_baud_clock;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) mem_q[wptr_q] <= i_wdata;
  end

  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_overflow = i_wr & full_q & ~i_reset;
  assign o_busy     = (state_q != IDLE) | ~empty_q;
  assign o_tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer.
// Baud clock toggles every 4 cycles unless frozen by a test.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       full, empty, ovf, busy, tx;

  int checks = 0;
  int failures = 0;
  bit baud_en = 1'b0;
  int bcnt = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.FIFO_DEPTH(16)) dut (
    .i_reset      (rst),
    .i_clock      (clk),
    .i_baud_clock (baud),
    .i_wr         (wr),
    .i_wdata      (wdata),
    .o_full       (full),
    .o_empty      (empty),
    .o_overflow   (ovf),
    .o_busy       (busy),
    .o_tx         (tx)
  );

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (baud_en) begin
        bcnt++;
        if (bcnt >= 4) begin
          bcnt = 0;
          baud = ~baud;
        end
      end
    end
  end

  task automatic rx_frame(input logic [7:0] b, input bit wait_start,
                          input string nm);
    logic [9:0] f;
    logic got;
    int n;
    bit bad;
    f = {1'b1, b, 1'b0};
    n = 0;
    @(negedge clk);
    if (wait_start) begin
      while (tx !== 1'b0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (tx !== 1'b0) begin
        failures++;
        $display("FAIL %s start: tx=%b required 0 within 400 cycles",
                 nm, tx);
        return;
      end
    end
    for (int k = 0; k < 10; k++) begin
      bad = 1'b0;
      got = f[k];
      for (int c = 0; c < 8; c++) begin
        if (k > 0 || c > 0) @(negedge clk);
        if (tx !== f[k]) begin
          bad = 1'b1;
          got = tx;
        end
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s bit%0d: tx=%b required %b for 8 cycles",
                 nm, k, got, f[k]);
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!(busy === 1'b0 && tx === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL %s idle: busy=%b tx=%b required busy=0 tx=1",
               nm, busy, tx);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL rst_tx: got %b required 1", tx);
    end
    checks++;
    if (full !== 1'b0) begin
      failures++; $display("FAIL rst_full: got %b required 0", full);
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++; $display("FAIL rst_empty: got %b required 1", empty);
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++; $display("FAIL rst_ovf: got %b required 0", ovf);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy: got %b required 0", busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    baud_en = 1'b1;
  endtask

  task automatic test_single;
    @(posedge clk); #1;
    wr = 1'b1; wdata = 8'hA5;
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    checks++;
    if (empty !== 1'b0) begin
      failures++; $display("FAIL single_empty: got %b required 0", empty);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL single_busy: got %b required 1", busy);
    end
    rx_frame(8'hA5, 1'b1, "single");
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || empty !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL single_done: busy=%b empty=%b tx=%b required 0 1 1",
               busy, empty, tx);
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    wr = 1'b1; wdata = 8'h00;
    @(posedge clk); #1;
    wdata = 8'hFF;
    @(posedge clk); #1;
    wr = 1'b0;
    rx_frame(8'h00, 1'b1, "b2b_f1");
    rx_frame(8'hFF, 1'b0, "b2b_f2");
    wait_idle("b2b");
  endtask

  task automatic test_fill_overflow;
    int pulses;
    pulses = 0;
    baud_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      wr = 1'b1; wdata = 8'h30 + 8'(i);
      @(negedge clk);
      if (ovf === 1'b1) pulses++;
      if (i == 15) begin
        checks++;
        if (full !== 1'b0) begin
          failures++; $display("FAIL fill_15: full=%b required 0", full);
        end
      end
      if (i == 16) begin
        checks++;
        if (full !== 1'b1) begin
          failures++; $display("FAIL fill_16: full=%b required 1", full);
        end
        checks++;
        if (ovf !== 1'b1) begin
          failures++; $display("FAIL ovf_17: ovf=%b required 1", ovf);
        end
      end
    end
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    checks++;
    if (ovf !== 1'b0 || full !== 1'b1) begin
      failures++;
      $display("FAIL ovf_after: ovf=%b full=%b required 0 1", ovf, full);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL ovf_pulses: got %0d required 1", pulses);
    end
    baud_en = 1'b1;
    rx_frame(8'h30, 1'b1, "fill_f0");
    for (int i = 1; i < 16; i++) rx_frame(8'h30 + 8'(i), 1'b0, "fill_fn");
    repeat (12) @(negedge clk);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL fill_drain: empty=%b full=%b required 1 0",
               empty, full);
    end
    begin
      bit bad;
      bad = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (tx !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        failures++; $display("FAIL fill_extra: tx=0 seen required 1");
      end
    end
  endtask

  task automatic test_push_pop;
    baud_en = 1'b0;
    @(posedge clk); #1;
    baud = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wr = 1'b1; wdata = 8'h5A;
    @(posedge clk); #1;
    wdata = 8'hC3;
    baud = 1'b1;
    bcnt = -1;
    baud_en = 1'b1;
    fork
      begin
        @(posedge clk); #1;
        wr = 1'b0;
      end
      rx_frame(8'h5A, 1'b1, "pp_f1");
    join
    checks++;
    if (empty !== 1'b0) begin
      failures++; $display("FAIL pp_count: empty=%b required 0", empty);
    end
    rx_frame(8'hC3, 1'b0, "pp_f2");
    wait_idle("pp");
  endtask

  task automatic test_reset_midframe;
    int n;
    bit bad;
    @(posedge clk); #1;
    wr = 1'b1; wdata = 8'h3C;
    @(posedge clk); #1;
    wdata = 8'h11;
    @(posedge clk); #1;
    wdata = 8'h22;
    @(posedge clk); #1;
    wr = 1'b0;
    n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (34) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL mid_d3: tx=%b required 1", tx);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst: tx=%b empty=%b busy=%b required 1 1 0",
               tx, empty, busy);
    end
    bad = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL mid_quiet: tx=0 seen required 1");
    end
  endtask

  task automatic test_tick_edge;
    bit bad;
    baud_en = 1'b0;
    @(posedge clk); #1;
    baud = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wr = 1'b1; wdata = 8'h01;
    @(posedge clk); #1;
    wr = 1'b0;
    baud = 1'b1;
    @(posedge clk);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL tick_hold: tx=1 seen required 0");
    end
    @(posedge clk); #1;
    baud = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      failures++; $display("FAIL tick_fall: tx=%b required 0", tx);
    end
    @(posedge clk); #1;
    baud = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL tick_d0: tx=%b required 1", tx);
    end
    @(posedge clk); #1;
    baud = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    baud = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      failures++; $display("FAIL tick_d1: tx=%b required 0", tx);
    end
    bcnt = 0;
    baud_en = 1'b1;
    wait_idle("tick");
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_fill_overflow;
    test_push_pop;
    test_reset_midframe;
    test_tick_edge;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
